// File: rtl/scan_display_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display:
// shadow digit registers, a scan prescaler and a 2-bit digit scan counter.
module scan_display_driver #(
    parameter int unsigned DIV = 100000
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [3:0] iC0,
    input  logic [3:0] iC1,
    input  logic [3:0] iC2,
    input  logic [3:0] iC3,
    input  logic       iLoad,
    input  logic       iEn,
    output logic       oS1,
    output logic       oS0,
    output logic [3:0] oZ,
    output logic [6:0] oSeg,
    output logic [3:0] oAn,
    output logic       oTick
);

    localparam int unsigned     PC_W   = $clog2(DIV);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(DIV - 1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      sel_q, sel_d;
    logic            tick_q, tick_d;
    logic            en_q;
    logic [3:0]      d_q [4];
    logic [3:0]      z;

    // Active-low {g,f,e,d,c,b,a} hex font.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        pc_d   = pc_q;
        sel_d  = sel_q;
        tick_d = 1'b0;
        if (iEn) begin
            if (pc_q == PC_MAX) begin
                pc_d   = '0;
                tick_d = 1'b1;
                sel_d  = sel_q + 2'd1;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pc_q   <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
            // NOTE: the shadow registers are reset because a cleared display must read back 0.
            d_q[0] <= '0;
            d_q[1] <= '0;
            d_q[2] <= '0;
            d_q[3] <= '0;
        end else begin
            pc_q   <= pc_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
            en_q   <= iEn;
            if (iLoad) begin
                d_q[0] <= iC0;
                d_q[1] <= iC1;
                d_q[2] <= iC2;
                d_q[3] <= iC3;
            end
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        z    = d_q[sel_q];
        oZ   = z;
        oSeg = hex_to_seg(z);
        oAn  = en_q ? ~(4'b0001 << sel_q) : 4'b1111;
        oS1  = sel_q[1];
        oS0  = sel_q[0];
    end

    assign oTick = tick_q;

endmodule

// File: tb/tb_scan_display_driver.sv
// Directed bench for scan_display_driver: a DIV=4 and a DIV=3 instance share stimulus.
module tb_scan_display_driver;

    logic       clk;
    logic       rst_n;
    logic [3:0] c0, c1, c2, c3;
    logic       load, en;

    logic       s1_4, s0_4, tick4;
    logic [3:0] z4, an4;
    logic [6:0] seg4;
    logic       s1_3, s0_3, tick3;
    logic [3:0] z3, an3;
    logic [6:0] seg3;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    scan_display_driver #(.DIV(4)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iC0(c0), .iC1(c1), .iC2(c2), .iC3(c3),
        .iLoad(load), .iEn(en), .oS1(s1_4), .oS0(s0_4), .oZ(z4), .oSeg(seg4),
        .oAn(an4), .oTick(tick4)
    );

    scan_display_driver #(.DIV(3)) dut3 (
        .iClk(clk), .iRst_n(rst_n), .iC0(c0), .iC1(c1), .iC2(c2), .iC3(c3),
        .iLoad(load), .iEn(en), .oS1(s1_3), .oS0(s0_3), .oZ(z3), .oSeg(seg3),
        .oAn(an3), .oTick(tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_after);
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        step();
        en    = en_after;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] esel;
        rst_n = 1'b0; en = 1'b1; load = 1'b0;
        c0 = 4'h0; c1 = 4'h0; c2 = 4'h0; c3 = 4'h0;
        repeat (2) step();
        n_checks++;
        if ({s1_4, s0_4, z4, seg4, an4, tick4} !== {2'b00, 4'h0, 7'b1000000, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset4: got s=%b%b z=%h seg=%b an=%b tick=%b", s1_4, s0_4, z4, seg4, an4, tick4);
        end
        n_checks++;
        if ({s1_3, s0_3, z3, seg3, an3, tick3} !== {2'b00, 4'h0, 7'b1000000, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset3: got s=%b%b z=%h seg=%b an=%b tick=%b", s1_3, s0_3, z3, seg3, an3, tick3);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            esel = (k >= 4) ? 2'd1 : 2'd0;
            n_checks++;
            if ({s1_4, s0_4, an4, tick4} !== {esel, ~(4'b0001 << esel), (k == 4)}) begin
                n_fail++;
                $display("FAIL release edge %0d: got s=%b%b an=%b tick=%b, want s=%b an=%b tick=%b",
                         k, s1_4, s0_4, an4, tick4, esel, ~(4'b0001 << esel), (k == 4));
            end
        end
    endtask

    task automatic test_scan_sequence();
        logic [3:0] exp_z   [4];
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        logic [1:0] esel;
        exp_z   = '{4'h0, 4'h5, 4'hA, 4'hF};
        exp_seg = '{7'b1000000, 7'b0010010, 7'b0001000, 7'b0001110};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_reset(1'b0);
        c3 = 4'hF; c2 = 4'hA; c1 = 4'h5; c0 = 4'h0;
        load = 1'b1;
        step();
        load = 1'b0;
        en   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            esel = 2'((k / 4) % 4);
            n_checks++;
            if ({s1_4, s0_4, z4, seg4, an4, tick4} !==
                {esel, exp_z[esel], exp_seg[esel], exp_an[esel], (k % 4 == 0)}) begin
                n_fail++;
                $display("FAIL scan edge %0d: got s=%b%b z=%h seg=%b an=%b tick=%b, want s=%b z=%h seg=%b an=%b",
                         k, s1_4, s0_4, z4, seg4, an4, tick4, esel, exp_z[esel], exp_seg[esel], exp_an[esel]);
            end
        end
    endtask

    // Continues from the end of the scan sequence: sel=0, pc=0.
    task automatic test_enable_pause();
        repeat (2) step();
        n_checks++;
        if ({s1_4, s0_4, an4, tick4} !== {2'b00, 4'b1110, 1'b0}) begin
            n_fail++;
            $display("FAIL pause pre: got s=%b%b an=%b tick=%b", s1_4, s0_4, an4, tick4);
        end
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if ({s1_4, s0_4, an4, tick4} !== {2'b00, 4'b1111, 1'b0}) begin
                n_fail++;
                $display("FAIL paused cycle %0d: got s=%b%b an=%b tick=%b, want s=00 an=1111 tick=0",
                         k, s1_4, s0_4, an4, tick4);
            end
        end
        en = 1'b1;
        step();
        n_checks++;
        if ({s1_4, s0_4, an4, tick4} !== {2'b00, 4'b1110, 1'b0}) begin
            n_fail++;
            $display("FAIL resume edge 1: got s=%b%b an=%b tick=%b, want s=00 an=1110 tick=0", s1_4, s0_4, an4, tick4);
        end
        step();
        n_checks++;
        if ({s1_4, s0_4, an4, tick4} !== {2'b01, 4'b1101, 1'b1}) begin
            n_fail++;
            $display("FAIL resume edge 2: got s=%b%b an=%b tick=%b, want s=01 an=1101 tick=1", s1_4, s0_4, an4, tick4);
        end
    endtask

    task automatic test_load_on_tick();
        do_reset(1'b1);
        c0 = 4'h2; c1 = 4'h3; c2 = 4'h4; c3 = 4'h6;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({s1_4, s0_4, z4, seg4} !== {2'b00, 4'h2, 7'b0100100}) begin
            n_fail++;
            $display("FAIL pre-tick digit: got s=%b%b z=%h seg=%b, want s=00 z=2 seg=0100100", s1_4, s0_4, z4, seg4);
        end
        c1   = 4'h7;
        load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if ({s1_4, s0_4, z4, seg4, tick4} !== {2'b01, 4'h7, 7'b1111000, 1'b1}) begin
            n_fail++;
            $display("FAIL load+tick: got s=%b%b z=%h seg=%b tick=%b, want s=01 z=7 seg=1111000 tick=1",
                     s1_4, s0_4, z4, seg4, tick4);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] esel;
        do_reset(1'b1);
        c0 = 4'h1; c1 = 4'h2; c2 = 4'h3; c3 = 4'h4;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (5) step();
        n_checks++;
        if ({s1_3, s0_3, z3, seg3, an3, tick3} !== {2'b10, 4'h3, 7'b0110000, 4'b1011, 1'b1}) begin
            n_fail++;
            $display("FAIL div3 sel2: got s=%b%b z=%h seg=%b an=%b tick=%b, want s=10 z=3 seg=0110000 an=1011 tick=1",
                     s1_3, s0_3, z3, seg3, an3, tick3);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s1_3, s0_3, z3, seg3, an3, tick3} !== {2'b00, 4'h0, 7'b1000000, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL async reset: got s=%b%b z=%h seg=%b an=%b tick=%b, want reset values",
                     s1_3, s0_3, z3, seg3, an3, tick3);
        end
        #2;
        en    = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            esel = 2'((k / 3) % 4);
            n_checks++;
            if ({s1_3, s0_3, z3, tick3} !== {esel, 4'h0, (k % 3 == 0)}) begin
                n_fail++;
                $display("FAIL cleared shadow edge %0d: got s=%b%b z=%h tick=%b, want s=%b z=0 tick=%b",
                         k, s1_3, s0_3, z3, tick3, esel, (k % 3 == 0));
            end
        end
    endtask

    task automatic test_decode();
        do_reset(1'b0);
        for (int v = 0; v < 16; v++) begin
            c0   = 4'(v);
            load = 1'b1;
            step();
            n_checks++;
            if ({z4, seg4, an4} !== {4'(v), SEG_TAB[v], 4'b1111}) begin
                n_fail++;
                $display("FAIL decode %h: got z=%h seg=%b an=%b, want seg=%b an=1111", v, z4, seg4, an4, SEG_TAB[v]);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_enable_pause();
        test_load_on_tick();
        test_async_reset();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_display_driver.md
# scan_display_driver

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It captures four 4-bit digit values into shadow registers and runs a prescaler plus a 2-bit scan counter. The counter's select bits drive the downstream 4:1 4-bit selector stage. It also produces the currently selected digit, its hex segment pattern and the active-low digit enables.

## Interface
- DIV, 100000, prescaler period in iClk cycles per scan step; legal range 2..2^20.
- iClk  in  1  system clock, all state updates on its rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iC0, iC1, iC2, iC3  in  4 each  digit values; iC0 is the rightmost digit.
- iLoad  in  1  when high at a clock edge, all four iCx are copied into the shadow registers.
- iEn  in  1  scan enable; low freezes scanning and blanks the display.
- oS1, oS0  out  1 each  scan select, {oS1,oS0} = index of the active digit; feeds the 4:1 selector.
- oZ  out  4  shadow value of the active digit.
- oSeg  out  7  active-low segments {g,f,e,d,c,b,a}.
- oAn  out  4  active-low digit enables, bit k selects digit k.
- oTick  out  1  one-cycle pulse on each scan step.

## Operation
- Prescaler: the counter pc has width clog2(DIV).
  - iEn=1 and pc=DIV-1: pc wraps to 0 and tick is asserted for that cycle.
  - iEn=1 otherwise: pc increments by 1.
  - iEn=0: pc holds its value. tick is 0.
- Scan counter: 2-bit register sel advances on tick in the order 0→1→2→3→0. It wraps modulo 4 and holds otherwise.
- Shadow registers: d0..d3 load from iC0..iC3 on any edge where iLoad=1, regardless of iEn.
- Outputs are driven only from registers. There is no combinational path from any input to any output.
  - {oS1,oS0} = sel.
  - oZ = d[sel].
  - oSeg = hex decode of oZ. Active-low codes {g..a}:
    - 0:1000000, 1:1111001, 2:0100100, 3:0110000
    - 4:0011001, 5:0010010, 6:0000010, 7:1111000
    - 8:0000000, 9:0010000, A:0001000, b:0000011
    - C:1000110, d:0100001, E:0000110, F:0001110
  - oAn = ~(4'b0001 << sel) when the enable register en_q=1; oAn = 4'b1111 when en_q=0.
  - en_q is iEn registered by one clock.
  - oTick = registered tick. It is high in the same cycle sel shows its new value.
- Reset (iRst_n=0, asynchronous): pc=0, sel=0, d0..d3=0, en_q=0, oTick=0.
  - Resulting outputs: oS1=0, oS0=0, oZ=0, oSeg=1000000, oAn=1111.
- Reset release: counting starts at the first edge with iRst_n=1 and iEn=1.

## Timing
- Scan step period is exactly DIV cycles while iEn stays high. A full refresh takes 4·DIV cycles.
- First step after reset: with iEn=1 from release, sel becomes 1 and oTick pulses on the DIV-th rising edge after release.
- Enable latency:
  - iEn rising at edge N: oAn lights digit sel after edge N.
  - iEn falling at edge N: oAn goes to 1111 after edge N, and pc/sel freeze at their edge-N values.
  - Re-enable resumes from the frozen pc. The prescaler is not restarted.
- Load latency: iLoad sampled at edge N; oZ and oSeg reflect the new data after edge N.
- Simultaneous iLoad and tick at the same edge: both take effect. After the edge, oZ = new d[new sel].
- Reset mid-scan: all state clears immediately. No partial tick pulse is produced.

## Test plan
- DIV=4, reset asserted then released, iEn=1, iLoad=0 → oAn=1111 and oSeg=1000000 during reset. oS=00 and oAn=1110 one cycle after release. oTick pulses on the 4th edge after release, then oS=01 and oAn=1101.
- DIV=4, iLoad pulse with iC3..iC0=F,A,5,0, iEn=1 for 16 cycles → oZ sequence 0,5,A,F, each held 4 cycles. oSeg follows 1000000, 0010010, 0001000, 0001110. oAn steps 1110, 1101, 1011, 0111 and wraps back to 1110.
- DIV=4, iEn dropped mid-step at pc=2 for 5 cycles → oAn=1111 and sel/oS held, no oTick. After re-enable, the next tick occurs 2 cycles later.
- DIV=4, iLoad with iC1 changed 3→7 on the same edge as the tick 0→1 → oZ=7 and oSeg=1111000 immediately after that edge.
- DIV=3, asynchronous reset pulse asserted between clock edges while sel=2 → outputs return to reset values without waiting for a clock edge, and the shadow registers read back 0.
- DIV=4, each hex value 0..F loaded into iC0 with sel=0 → oSeg matches the 16-entry decode list exactly.
